// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the 5-stage pipeline: start/step/stop/halt of the
// shared pipeline enable, plus host/fetch arbitration of the instruction-memory port.
module cpu_run_ctrl #(
  parameter logic [4:0] HALT_OP = 5'b00001,
  parameter int         CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             stop,
  input  logic             host_we,
  input  logic [7:0]       host_addr,
  input  logic [15:0]      host_data,
  output logic             host_ack,
  input  logic [7:0]       if_addr,
  input  logic [15:0]      id_ir,
  output logic [7:0]       mem_addr,
  output logic             mem_we,
  output logic [15:0]      mem_wdata,
  output logic             state,
  output logic             halted,
  output logic             step_done,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    HALTED
  } fsm_t;

  fsm_t fsm;
  logic stopped;
  logic halt_seen;
  logic unused_ir;

  assign stopped   = (fsm == IDLE) || (fsm == HALTED);
  assign halt_seen = (id_ir[15:11] == HALT_OP);
  assign unused_ir = ^id_ir[10:0];

  // The port belongs to the host only while the pipeline is not fetching.
  assign mem_addr  = stopped ? host_addr : if_addr;
  assign mem_we    = host_we & stopped;
  assign mem_wdata = host_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm       <= IDLE;
      state     <= 1'b0;
      halted    <= 1'b0;
      host_ack  <= 1'b0;
      step_done <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees the pre-edge state and
      // later assignments below (e.g. the counter clear) override the defaults above them.
      host_ack  <= 1'b0;
      step_done <= 1'b0;
      if (state && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 1'b1;

      unique case (fsm)
        IDLE, HALTED: begin
          if (host_we) begin
            host_ack <= 1'b1;
          end else if (start || step) begin
            fsm    <= start ? RUN : STEP;
            state  <= 1'b1;
            halted <= 1'b0;
            // Resuming from IDLE keeps the count; a fresh start after HALT does not.
            if (fsm == HALTED) cycle_cnt <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            fsm   <= IDLE;
            state <= 1'b0;
          end else if (halt_seen) begin
            fsm    <= HALTED;
            state  <= 1'b0;
            halted <= 1'b1;
          end
        end
        STEP: begin
          state     <= 1'b0;
          step_done <= 1'b1;
          if (halt_seen) begin
            fsm    <= HALTED;
            halted <= 1'b1;
          end else begin
            fsm <= IDLE;
          end
        end
        default: begin
          fsm   <= IDLE;
          state <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: a behavioural run/step/halt model is
// compared every cycle, with directed scenarios pinned by literal expectations.
module tb_cpu_run_ctrl;

  logic        clock;
  logic        reset;
  logic        start, step, stop, host_we;
  logic [7:0]  host_addr, if_addr, mem_addr;
  logic [15:0] host_data, id_ir, mem_wdata;
  logic        host_ack, mem_we, state, halted, step_done;
  logic [15:0] cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  cpu_run_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .step      (step),
    .stop      (stop),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_data (host_data),
    .host_ack  (host_ack),
    .if_addr   (if_addr),
    .id_ir     (id_ir),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .state     (state),
    .halted    (halted),
    .step_done (step_done),
    .cycle_cnt (cycle_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the pipeline is either free-running, doing one step, or
  // parked (optionally halted); the counter is a saturating integer.
  bit          m_run, m_step, m_halt, m_ack, m_done;
  int unsigned m_cnt;
  bit          m_on, m_halt_op;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_step = 0; m_halt = 0; m_ack = 0; m_done = 0; m_cnt = 0;
    end else begin
      m_on      = m_run || m_step;
      m_halt_op = (id_ir[15:11] == 5'd1);
      m_ack     = 0;
      m_done    = 0;
      if (m_on) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      if (m_run) begin
        if (stop) m_run = 0;
        else if (m_halt_op) begin m_run = 0; m_halt = 1; end
      end else if (m_step) begin
        m_step = 0;
        m_done = 1;
        if (m_halt_op) m_halt = 1;
      end else if (host_we) begin
        m_ack = 1;
      end else if (start || step) begin
        if (m_halt) m_cnt = 0;
        m_halt = 0;
        if (start) m_run = 1; else m_step = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("state",     32'(state),     32'(m_run || m_step));
      check("halted",    32'(halted),    32'(m_halt));
      check("host_ack",  32'(host_ack),  32'(m_ack));
      check("step_done", 32'(step_done), 32'(m_done));
      check("cycle_cnt", 32'(cycle_cnt), m_cnt);
      check("mem_we",    32'(mem_we),    32'(host_we && !(m_run || m_step)));
      check("mem_addr",  32'(mem_addr),  32'((m_run || m_step) ? if_addr : host_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(host_data));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1; start = 0; step = 0; stop = 0; host_we = 0;
    host_addr = 8'h00; host_data = 16'h0000; if_addr = 8'h00; id_ir = 16'h0000;
    #1 reset = 0;
    repeat (2) @(posedge clock);
    #2 reset = 1;
    cmp_en = 1;
    @(negedge clock);
    check("rst_state", 32'(state), 0);
    check("rst_cnt", 32'(cycle_cnt), 0);
    check("rst_ack", 32'(host_ack), 0);

    // Three back-to-back host writes while idle.
    host_we = 1; host_addr = 8'h00; host_data = 16'h1234;
    @(negedge clock);
    check("wr0_we", 32'(mem_we), 1);
    check("wr0_addr", 32'(mem_addr), 32'h00);
    check("wr0_data", 32'(mem_wdata), 32'h1234);
    tick();
    host_addr = 8'h01; host_data = 16'h5678;
    @(negedge clock);
    check("wr1_ack", 32'(host_ack), 1);
    check("wr1_addr", 32'(mem_addr), 32'h01);
    tick();
    host_addr = 8'h02; host_data = 16'h0800;
    tick();
    host_we = 0;
    @(negedge clock);
    check("wr2_ack", 32'(host_ack), 1);
    check("wr_state", 32'(state), 0);
    tick();
    @(negedge clock);
    check("wr_ack_end", 32'(host_ack), 0);

    // Free run from idle with the fetch stage owning the port.
    if_addr = 8'h05; start = 1;
    tick();
    start = 0;
    @(negedge clock);
    check("run_state", 32'(state), 1);
    check("run_addr", 32'(mem_addr), 32'h05);
    repeat (3) tick();
    @(negedge clock);
    check("run_cnt3", 32'(cycle_cnt), 3);

    // HALT opcode in RUN, then a fresh start clears the counter.
    id_ir = 16'h0800;
    tick();
    id_ir = 16'h0000;
    @(negedge clock);
    check("halt_flag", 32'(halted), 1);
    check("halt_state", 32'(state), 0);
    check("halt_cnt", 32'(cycle_cnt), 4);
    repeat (2) tick();
    @(negedge clock);
    check("halt_frozen", 32'(cycle_cnt), 4);
    start = 1;
    tick();
    start = 0;
    @(negedge clock);
    check("restart_cnt", 32'(cycle_cnt), 0);
    check("restart_halted", 32'(halted), 0);
    tick();
    stop = 1;
    tick();
    stop = 0;

    // Single step from idle resumes the count.
    step = 1;
    tick();
    step = 0;
    @(negedge clock);
    check("step_state", 32'(state), 1);
    tick();
    @(negedge clock);
    check("step_done", 32'(step_done), 1);
    check("step_idle", 32'(state), 0);
    check("step_cnt", 32'(cycle_cnt), 3);
    tick();
    @(negedge clock);
    check("step_done_end", 32'(step_done), 0);

    // start and step together: start wins.
    start = 1; step = 1;
    tick();
    start = 0; step = 0;
    tick();
    @(negedge clock);
    check("both_run", 32'(state), 1);

    // stop beats HALT in the same cycle.
    stop = 1; id_ir = 16'h0800;
    tick();
    stop = 0; id_ir = 16'h0000;
    @(negedge clock);
    check("stop_halted", 32'(halted), 0);
    check("stop_state", 32'(state), 0);

    // Host write attempted while running is refused.
    start = 1;
    tick();
    start = 0; host_we = 1; host_addr = 8'h40; host_data = 16'hBEEF;
    @(negedge clock);
    check("run_wr_we", 32'(mem_we), 0);
    check("run_wr_addr", 32'(mem_addr), 32'h05);
    tick();
    @(negedge clock);
    check("run_wr_ack", 32'(host_ack), 0);
    host_we = 0; stop = 1;
    tick();
    stop = 0;

    // HALT seen during a step goes to HALTED and still flags step_done.
    step = 1;
    tick();
    step = 0; id_ir = 16'h0800;
    tick();
    id_ir = 16'h0000;
    @(negedge clock);
    check("stephalt_done", 32'(step_done), 1);
    check("stephalt_flag", 32'(halted), 1);
    check("stephalt_state", 32'(state), 0);

    // Long run from HALTED (counter cleared) up to saturation.
    start = 1;
    tick();
    start = 0;
    repeat (65534) tick();
    @(negedge clock);
    check("sat_fffe", 32'(cycle_cnt), 32'hFFFE);
    repeat (4) tick();
    @(negedge clock);
    check("sat_ffff", 32'(cycle_cnt), 32'hFFFF);
    check("sat_state", 32'(state), 1);

    // Asynchronous reset mid-run with a host write pending.
    tick();
    host_we = 1; host_addr = 8'h10;
    #1 reset = 0;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_ack", 32'(host_ack), 0);
    check("arst_cnt", 32'(cycle_cnt), 0);
    host_we = 0;
    tick();
    reset = 1;
    repeat (2) tick();
    @(negedge clock);
    check("post_rst_ack", 32'(host_ack), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
